// File: rtl/score_ctrl.sv
// Two-player score keeper: counts points, spaces out serves with an idle
// delay, and declares a winner at WIN_SCORE. All outputs are registered.
module score_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve,
  output logic       serve_side,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, GAME_OVER} state_t;

  localparam logic [3:0]  WIN = 4'(WIN_SCORE);
  localparam logic [15:0] DLY = 16'(SERVE_DELAY);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  s1_n, s2_n, inc1, inc2;
  logic        serve_n, side_n, go_n, win_n;
  logic        solo_p1, solo_p2;

  // Saturating increments; a score can never pass WIN_SCORE.
  assign inc1    = (score_p1 < WIN) ? score_p1 + 4'd1 : score_p1;
  assign inc2    = (score_p2 < WIN) ? score_p2 + 4'd1 : score_p2;
  assign solo_p1 = point_p1 & ~point_p2;
  assign solo_p2 = point_p2 & ~point_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      score_p1   <= '0;
      score_p2   <= '0;
      serve      <= 1'b0;
      serve_side <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      score_p1   <= s1_n;
      score_p2   <= s2_n;
      serve      <= serve_n;
      serve_side <= side_n;
      game_over  <= go_n;
      winner     <= win_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, GAME_OVER: if (start) state_n = SERVE_WAIT;
      SERVE_WAIT:      if (cnt == 16'd0) state_n = PLAY;
      PLAY: begin
        if (solo_p1)                  state_n = (inc1 == WIN) ? GAME_OVER : SERVE_WAIT;
        else if (solo_p2)             state_n = (inc2 == WIN) ? GAME_OVER : SERVE_WAIT;
        else if (point_p1 & point_p2) state_n = SERVE_WAIT;
      end
      default:         state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n   = cnt;
    s1_n    = score_p1;
    s2_n    = score_p2;
    serve_n = 1'b0;
    side_n  = serve_side;
    go_n    = game_over;
    win_n   = winner;
    case (state)
      IDLE, GAME_OVER: if (start) begin
        cnt_n  = DLY;
        s1_n   = '0;
        s2_n   = '0;
        side_n = 1'b0;
        go_n   = 1'b0;
      end
      SERVE_WAIT: begin
        if (cnt == 16'd0) serve_n = 1'b1;
        else              cnt_n   = cnt - 16'd1;
      end
      PLAY: begin
        // Loser of the rally serves next; a let keeps the server.
        if (solo_p1) begin
          s1_n   = inc1;
          side_n = 1'b1;
        end else if (solo_p2) begin
          s2_n   = inc2;
          side_n = 1'b0;
        end
        if (state_n == GAME_OVER) begin
          go_n  = 1'b1;
          win_n = solo_p2;
        end else if (state_n == SERVE_WAIT) begin
          cnt_n = DLY;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: a small score model pushes expected output
// snapshots to a scoreboard queue, popped and compared after each edge.
module tb_score_ctrl;
  localparam int SD = 4;
  localparam int WS = 3;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve, serve_side, game_over, winner;

  score_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .point_p1(point_p1), .point_p2(point_p2),
    .score_p1(score_p1), .score_p2(score_p2), .serve(serve), .serve_side(serve_side),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] s1, s2;
    logic       side, go, win;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, passed = 0;
  logic [3:0] m1 = 0, m2 = 0;
  logic       mside = 0, mgo = 0, mwin = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.s1 = m1; e.s2 = m2; e.side = mside; e.go = mgo; e.win = mwin;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".score_p1"},   int'(score_p1),   int'(e.s1));
    chk({e.tag, ".score_p2"},   int'(score_p2),   int'(e.s2));
    chk({e.tag, ".serve_side"}, int'(serve_side), int'(e.side));
    chk({e.tag, ".game_over"},  int'(game_over),  int'(e.go));
    if (e.go) chk({e.tag, ".winner"}, int'(winner), int'(e.win));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Counts edges from the accepting edge until serve is seen; noise drives
  // point/start inputs during the wait, which must be ignored.
  task automatic wait_serve(input string tag, input logic noise);
    int n = 0;
    do begin
      point_p1 = noise; point_p2 = noise; start = noise;
      step();
      n++;
    end while (!serve && n < 50);
    point_p1 = 0; point_p2 = 0; start = 0;
    chk({tag, ".serve_latency"}, n, SD + 1);
    push_exp({tag, ".at_serve"});
    pop_check();
    step();
    chk({tag, ".serve_one_cycle"}, int'(serve), 0);
  endtask

  // Leaves the DUT one cycle into PLAY so the next point lands in PLAY.
  task automatic serve_then_point(input string tag, input logic p1, input logic p2);
    point_p1 = p1; point_p2 = p2;
    if (p1 && !p2) begin
      if (m1 < WS) m1++;
      mside = 1;
    end else if (p2 && !p1) begin
      if (m2 < WS) m2++;
      mside = 0;
    end
    if (m1 == WS || m2 == WS) begin
      mgo = 1; mwin = (m2 == WS);
    end
    push_exp(tag);
    step();
    point_p1 = 0; point_p2 = 0;
    pop_check();
  endtask

  task automatic no_serve(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (serve) seen++;
    end
    chk({tag, ".no_serve"}, seen, 0);
  endtask

  task automatic do_start(input string tag);
    start = 1;
    m1 = 0; m2 = 0; mside = 0; mgo = 0;
    push_exp(tag);
    step();
    start = 0;
    pop_check();
  endtask

  initial begin
    #2;
    push_exp("reset");
    pop_check();
    chk("reset.serve", int'(serve), 0);
    #10 reset = 0;
    no_serve("idle", 8);

    do_start("start1");
    wait_serve("serve1", 1'b0);
    // Back up into the serve cycle is not possible; the point lands in the
    // second PLAY cycle, which is still PLAY.
    serve_then_point("p2_point", 1'b0, 1'b1);
    wait_serve("serve2", 1'b1);
    serve_then_point("p1_point", 1'b1, 1'b0);
    wait_serve("serve3", 1'b1);
    chk("serve3.side", int'(serve_side), 1);
    serve_then_point("let", 1'b1, 1'b1);
    wait_serve("serve4", 1'b0);
    serve_then_point("p1_point2", 1'b1, 1'b0);
    wait_serve("serve5", 1'b0);
    serve_then_point("p1_win", 1'b1, 1'b0);
    chk("win.game_over", int'(game_over), 1);
    chk("win.winner", int'(winner), 0);

    point_p1 = 1; point_p2 = 0;
    step();
    point_p1 = 0; point_p2 = 1;
    step();
    point_p2 = 0;
    push_exp("go_hold");
    pop_check();
    no_serve("game_over", 10);

    do_start("restart");
    chk("restart.game_over", int'(game_over), 0);
    wait_serve("serve6", 1'b0);
    serve_then_point("r_p1a", 1'b1, 1'b0);
    wait_serve("serve7", 1'b0);
    serve_then_point("r_p1b", 1'b1, 1'b0);
    wait_serve("serve8", 1'b0);
    serve_then_point("r_p2", 1'b0, 1'b1);
    chk("pre_reset.score_p1", int'(score_p1), 2);
    step(); step();

    // Asynchronous reset between edges inside SERVE_WAIT.
    #2 reset = 1;
    #1;
    m1 = 0; m2 = 0; mside = 0; mgo = 0; mwin = 0;
    push_exp("async_reset");
    pop_check();
    chk("async_reset.serve", int'(serve), 0);
    chk("async_reset.winner", int'(winner), 0);
    step();
    #3 reset = 0;
    no_serve("after_reset", 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
